// File: rtl/riscv_defs_pkg.sv
// Shared RV32I definitions for the ALU-subset pipeline: opcodes, function
// codes, ALU operation enum, pipeline register layouts and immediate helpers.
package riscv_defs_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
  } alu_op_e;

  // Decoded control; an all-zero value is a bubble (no write, rd = x0).
  typedef struct packed {
    logic       we;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_imm;
    alu_op_e    op;
    logic [31:0] imm;
  } dec_t;

  typedef struct packed {
    dec_t        ctl;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } id_ex_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] result;
  } wb_t;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'h000};
  endfunction

endpackage

// File: rtl/riscv_pipeline_core_if.sv
// Instruction fetch bus between the core and its ROM: word address out,
// instruction word back in the same cycle.
interface riscv_pipeline_core_if #(parameter int AW = 10);
  logic [AW-1:0] addr;
  logic [31:0]   inst;

  modport master (output addr, input inst);
  modport slave  (input addr, output inst);
endinterface

// File: rtl/riscv_pipeline_core_regfile.sv
// 32 x 32-bit integer register file: two write-first read ports, one write
// port, x0 hardwired to zero. Architectural state is cleared by reset.
module regfile (
  input  logic        clk,
  input  logic        rstn,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] regs_mem [0:31];

  // Unlike the ROM, every register must read zero right after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regs_mem[i] <= '0;
    end else if (we == 1'b1 && waddr != 5'd0) begin
      regs_mem[waddr] <= wdata;
    end
  end

  // NOTE: each output gets a default before any condition, so no latch forms.
  always_comb begin
    rdata1 = regs_mem[raddr1];
    if (we == 1'b1 && waddr != 5'd0 && waddr == raddr1) rdata1 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
  end

  always_comb begin
    rdata2 = regs_mem[raddr2];
    if (we == 1'b1 && waddr != 5'd0 && waddr == raddr2) rdata2 = wdata;
    if (raddr2 == 5'd0) rdata2 = '0;
  end
endmodule

// File: rtl/riscv_pipeline_core_rom.sv
// Instruction ROM: a generic word array with asynchronous read, wrapped so
// the core sees only the fetch bus. Contents are preloaded from outside.
module gnrl_rom #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);
  logic [DW-1:0] mem_r [0:DEPTH-1];

  // NOTE: storage arrays carry no reset so they map to RAM/ROM macros, and
  // clocked state is always written with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (we) mem_r[waddr] <= wdata;
  end

  assign rdata = mem_r[raddr];
endmodule

module rom #(
  parameter int DEPTH = 1024
) (
  input logic                   clk,
  riscv_pipeline_core_if.slave  fetch
);
  localparam int AW = $clog2(DEPTH);

  // Write port is tied off in the core; contents come from preload only.
  gnrl_rom #(.DW(32), .DEPTH(DEPTH)) u_gnrl_rom (
    .clk   (clk),
    .we    (1'b0),
    .waddr ({AW{1'b0}}),
    .wdata (32'h0),
    .raddr (fetch.addr),
    .rdata (fetch.inst)
  );
endmodule

// File: rtl/riscv_pipeline_core.sv
// Five-stage RV32I ALU-subset core (IF/ID/EX/MEM/WB) fetching from an
// internal ROM; full EX-stage forwarding, so it never stalls.
module riscv_pipeline_core
  import riscv_defs_pkg::*;
#(
  parameter int          ROM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic rstn
);
  localparam int AW = $clog2(ROM_DEPTH);

  // PC only needs the byte-address bits that reach the ROM; the add wraps
  // modulo ROM_DEPTH*4 on its own.
  logic [AW+1:0] pc;
  logic [31:0]   if_id_inst;
  id_ex_t        id_ex;
  wb_t           ex_mem;
  wb_t           mem_wb;

  dec_t          dec;
  logic [31:0]   rf_rdata1, rf_rdata2;
  logic [31:0]   op_a, op_b, alu_b, alu_y;
  logic [2:0]    f3;
  logic [6:0]    f7;

  riscv_pipeline_core_if #(.AW(AW)) fetch_bus ();

  rom #(.DEPTH(ROM_DEPTH)) u_rom (
    .clk   (clk),
    .fetch (fetch_bus)
  );

  assign fetch_bus.addr = pc[AW+1:2];

  regfile u_regfile (
    .clk    (clk),
    .rstn   (rstn),
    .we     (mem_wb.we),
    .waddr  (mem_wb.rd),
    .wdata  (mem_wb.result),
    .raddr1 (dec.rs1),
    .raddr2 (dec.rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  // ID: anything outside the supported subset collapses to a bubble.
  assign f3 = if_id_inst[14:12];
  assign f7 = if_id_inst[31:25];

  always_comb begin
    dec    = '0;
    dec.op = ALU_ADD;
    case (if_id_inst[6:0])
      OPC_LUI: begin
        dec.we      = 1'b1;
        dec.rd      = if_id_inst[11:7];
        dec.use_imm = 1'b1;
        dec.op      = ALU_LUI;
        dec.imm     = imm_u(if_id_inst);
      end
      OPC_OP_IMM: begin
        dec.we      = 1'b1;
        dec.rd      = if_id_inst[11:7];
        dec.rs1     = if_id_inst[19:15];
        dec.use_imm = 1'b1;
        dec.imm     = imm_i(if_id_inst);
        case (f3)
          F3_ADD_SUB: dec.op = ALU_ADD;
          F3_SLT:     dec.op = ALU_SLT;
          F3_SLTU:    dec.op = ALU_SLTU;
          F3_XOR:     dec.op = ALU_XOR;
          F3_OR:      dec.op = ALU_OR;
          F3_AND:     dec.op = ALU_AND;
          F3_SLL:     if (f7 == F7_BASE) dec.op = ALU_SLL; else dec = '0;
          F3_SRL_SRA: begin
            if (f7 == F7_BASE)     dec.op = ALU_SRL;
            else if (f7 == F7_ALT) dec.op = ALU_SRA;
            else                   dec = '0;
          end
          default:    dec = '0;
        endcase
      end
      OPC_OP: begin
        dec.we  = 1'b1;
        dec.rd  = if_id_inst[11:7];
        dec.rs1 = if_id_inst[19:15];
        dec.rs2 = if_id_inst[24:20];
        case ({f7, f3})
          {F7_BASE, F3_ADD_SUB}: dec.op = ALU_ADD;
          {F7_ALT,  F3_ADD_SUB}: dec.op = ALU_SUB;
          {F7_BASE, F3_SLL}:     dec.op = ALU_SLL;
          {F7_BASE, F3_SLT}:     dec.op = ALU_SLT;
          {F7_BASE, F3_SLTU}:    dec.op = ALU_SLTU;
          {F7_BASE, F3_XOR}:     dec.op = ALU_XOR;
          {F7_BASE, F3_SRL_SRA}: dec.op = ALU_SRL;
          {F7_ALT,  F3_SRL_SRA}: dec.op = ALU_SRA;
          {F7_BASE, F3_OR}:      dec.op = ALU_OR;
          {F7_BASE, F3_AND}:     dec.op = ALU_AND;
          default:               dec = '0;
        endcase
      end
      default: dec = '0;
    endcase
  end

  // EX operands: the younger producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    op_a = id_ex.rs1_val;
    if (ex_mem.we && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.ctl.rs1)
      op_a = ex_mem.result;
    else if (mem_wb.we && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.ctl.rs1)
      op_a = mem_wb.result;

    op_b = id_ex.rs2_val;
    if (ex_mem.we && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.ctl.rs2)
      op_b = ex_mem.result;
    else if (mem_wb.we && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.ctl.rs2)
      op_b = mem_wb.result;

    alu_b = id_ex.ctl.use_imm ? id_ex.ctl.imm : op_b;
  end

  always_comb begin
    alu_y = '0;
    case (id_ex.ctl.op)
      ALU_ADD:  alu_y = op_a + alu_b;
      ALU_SUB:  alu_y = op_a - alu_b;
      ALU_SLL:  alu_y = op_a << alu_b[4:0];
      ALU_SLT:  alu_y = {31'b0, $signed(op_a) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'b0, op_a < alu_b};
      ALU_XOR:  alu_y = op_a ^ alu_b;
      ALU_SRL:  alu_y = op_a >> alu_b[4:0];
      ALU_SRA:  alu_y = $unsigned($signed(op_a) >>> alu_b[4:0]);
      ALU_OR:   alu_y = op_a | alu_b;
      ALU_AND:  alu_y = op_a & alu_b;
      ALU_LUI:  alu_y = alu_b;
      default:  alu_y = '0;
    endcase
  end

  // Reset drops every in-flight instruction by refilling all stages with bubbles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc         <= RESET_PC[AW+1:0];
      if_id_inst <= NOP_INST;
      id_ex      <= '0;
      ex_mem     <= '0;
      mem_wb     <= '0;
    end else begin
      pc            <= pc + (AW+2)'(4);
      if_id_inst    <= fetch_bus.inst;
      id_ex.ctl     <= dec;
      id_ex.rs1_val <= rf_rdata1;
      id_ex.rs2_val <= rf_rdata2;
      ex_mem.we     <= id_ex.ctl.we;
      ex_mem.rd     <= id_ex.ctl.rd;
      ex_mem.result <= alu_y;
      mem_wb        <= ex_mem;
    end
  end
endmodule

// File: tb/tb_riscv_pipeline_core.sv
// Directed-program bench for riscv_pipeline_core: programs are preloaded into
// the ROM, expected register values go into a scoreboard queue, and a monitor
// compares them against the register file on the falling clock edge.
module tb_riscv_pipeline_core;

  localparam int ROM_DEPTH = 1024;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  riscv_pipeline_core #(.ROM_DEPTH(ROM_DEPTH), .RESET_PC(32'h0)) dut (
    .clk  (clk),
    .rstn (rstn)
  );

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] prog [$];
  int          total = 0;
  int          bad = 0;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] i_type(input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return i_type(3'b000, rd, rs1, imm);
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = dut.u_regfile.regs_mem[e.idx];
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s x%0d: got %08h, required %08h", e.name, e.idx, act, e.val);
      end
    end
  end

  task automatic expect_reg(input string name, input int idx, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.idx  = idx;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int t = 0; t < 4; t++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks left unserviced, required 0", sb.size());
      sb.delete();
    end
  endtask

  // ---------------- program load / run ----------------
  task automatic load_rom();
    for (int i = 0; i < ROM_DEPTH; i++) dut.u_rom.u_gnrl_rom.mem_r[i] = 32'h00000013;
    for (int i = 0; i < prog.size(); i++) dut.u_rom.u_gnrl_rom.mem_r[i] = prog[i];
  endtask

  task automatic enter_reset_and_load();
    @(negedge clk);
    rstn = 1'b0;
    load_rom();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic build_chain();
    prog.delete();
    prog.push_back(addi(1, 0, 12'd1));
    prog.push_back(addi(2, 1, 12'd1));
    prog.push_back(addi(3, 2, 12'd1));
    prog.push_back(addi(4, 3, 12'd1));
    prog.push_back(addi(5, 4, 12'd1));
  endtask

  initial begin
    // 1: independent ADDIs
    prog.delete();
    for (int i = 1; i <= 5; i++) prog.push_back(addi(5'(i), 0, 12'(i)));
    enter_reset_and_load();
    release_reset();
    run(50);
    for (int i = 1; i <= 5; i++) expect_reg("indep", i, 32'(i));
    drain();

    // 2: chained dependencies plus EX/MEM-over-MEM/WB priority
    build_chain();
    prog.push_back(addi(6, 0, 12'd1));
    prog.push_back(addi(6, 0, 12'd2));
    prog.push_back(addi(7, 6, 12'd0));
    enter_reset_and_load();
    release_reset();
    run(50);
    for (int i = 1; i <= 5; i++) expect_reg("chain", i, 32'(i));
    expect_reg("fwd_prio", 6, 32'd2);
    expect_reg("fwd_prio", 7, 32'd2);
    drain();

    // 3: negative / wrap / immediate edge cases
    prog.delete();
    prog.push_back(addi(1, 0, 12'hFFF));
    prog.push_back(addi(2, 1, 12'd1));
    prog.push_back(i_type(3'b011, 3, 1, 12'hFFF));   // sltiu
    prog.push_back(i_type(3'b010, 4, 1, 12'h000));   // slti
    prog.push_back(i_type(3'b101, 5, 1, 12'h404));   // srai 4
    prog.push_back(i_type(3'b101, 6, 1, 12'h004));   // srli 4
    prog.push_back(i_type(3'b100, 7, 1, 12'h555));   // xori
    prog.push_back(i_type(3'b111, 8, 1, 12'h800));   // andi -2048
    prog.push_back(i_type(3'b110, 9, 0, 12'h7FF));   // ori
    prog.push_back(i_type(3'b001, 10, 1, 12'h01F));  // slli 31
    prog.push_back(i_type(3'b011, 11, 0, 12'hFFF));  // sltiu 0 < 0xFFFFFFFF
    prog.push_back(i_type(3'b010, 12, 0, 12'hFFF));  // slti 0 < -1
    prog.push_back(i_type(3'b001, 13, 1, 12'h41F));  // slli with bad funct7
    enter_reset_and_load();
    release_reset();
    run(50);
    expect_reg("addi_m1", 1, 32'hFFFFFFFF);
    expect_reg("addi_wrap", 2, 32'h00000000);
    expect_reg("sltiu", 3, 32'd0);
    expect_reg("slti", 4, 32'd1);
    expect_reg("srai", 5, 32'hFFFFFFFF);
    expect_reg("srli", 6, 32'h0FFFFFFF);
    expect_reg("xori", 7, 32'hFFFFFAAA);
    expect_reg("andi", 8, 32'hFFFFF800);
    expect_reg("ori", 9, 32'h000007FF);
    expect_reg("slli31", 10, 32'h80000000);
    expect_reg("sltiu_max", 11, 32'd1);
    expect_reg("slti_neg", 12, 32'd0);
    expect_reg("bad_slli", 13, 32'd0);
    drain();

    // 4: x0 protection, including forwarding of a discarded x0 result
    prog.delete();
    prog.push_back(addi(0, 0, 12'd7));
    prog.push_back(addi(1, 0, 12'd0));
    prog.push_back(addi(2, 0, 12'd5));
    prog.push_back(r_type(7'h00, 3'b000, 3, 0, 0));
    enter_reset_and_load();
    release_reset();
    run(50);
    expect_reg("x0_keep", 0, 32'd0);
    expect_reg("x0_fwd", 1, 32'd0);
    expect_reg("x0_fwd2", 2, 32'd5);
    expect_reg("x0_add", 3, 32'd0);
    drain();

    // 5: R-type and LUI, plus unsupported words acting as NOPs
    prog.delete();
    prog.push_back(lui(1, 20'h12345));
    prog.push_back(addi(2, 0, 12'd3));
    prog.push_back(r_type(7'h20, 3'b000, 3, 1, 2));  // sub
    prog.push_back(r_type(7'h00, 3'b001, 4, 2, 2));  // sll
    prog.push_back(r_type(7'h00, 3'b010, 5, 3, 1));  // slt
    prog.push_back(r_type(7'h00, 3'b100, 6, 1, 2));  // xor
    prog.push_back(r_type(7'h00, 3'b110, 7, 2, 4));  // or
    prog.push_back(r_type(7'h00, 3'b111, 8, 1, 3));  // and
    prog.push_back(r_type(7'h00, 3'b101, 9, 1, 2));  // srl
    prog.push_back(addi(10, 0, 12'hFF8));
    prog.push_back(r_type(7'h20, 3'b101, 11, 10, 2)); // sra
    prog.push_back(r_type(7'h00, 3'b011, 12, 2, 10)); // sltu
    prog.push_back(r_type(7'h00, 3'b010, 13, 10, 2)); // slt
    prog.push_back(r_type(7'h00, 3'b000, 14, 10, 2)); // add
    prog.push_back(r_type(7'h01, 3'b000, 15, 2, 2));  // mul: unsupported
    prog.push_back(32'hFFFFFFFF);
    prog.push_back(r_type(7'h00, 3'b011, 16, 10, 2)); // sltu
    enter_reset_and_load();
    release_reset();
    run(50);
    expect_reg("lui", 1, 32'h12345000);
    expect_reg("addi3", 2, 32'd3);
    expect_reg("sub", 3, 32'h12344FFD);
    expect_reg("sll", 4, 32'd24);
    expect_reg("slt", 5, 32'd1);
    expect_reg("xor", 6, 32'h12345003);
    expect_reg("or", 7, 32'h0000001B);
    expect_reg("and", 8, 32'h12344000);
    expect_reg("srl", 9, 32'h02468A00);
    expect_reg("addi_m8", 10, 32'hFFFFFFF8);
    expect_reg("sra", 11, 32'hFFFFFFFF);
    expect_reg("sltu", 12, 32'd1);
    expect_reg("slt_neg", 13, 32'd1);
    expect_reg("add_neg", 14, 32'hFFFFFFFB);
    expect_reg("mul_nop", 15, 32'd0);
    expect_reg("sltu_big", 16, 32'd0);
    drain();

    // 6: reset clears state asynchronously, then a mid-run reset
    @(posedge clk);
    #1 rstn = 1'b0;
    for (int i = 0; i < 32; i++) expect_reg("async_clr", i, 32'd0);
    drain();
    build_chain();
    load_rom();
    release_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    for (int i = 0; i < 32; i++) expect_reg("rst_hold", i, 32'd0);
    drain();
    @(posedge clk);
    @(posedge clk);
    release_reset();
    run(50);
    for (int i = 1; i <= 5; i++) expect_reg("rst_rerun", i, 32'(i));
    drain();

    // 7: PC wraps from the last ROM word back to word 0
    prog.delete();
    prog.push_back(addi(1, 1, 12'd1));
    enter_reset_and_load();
    dut.u_rom.u_gnrl_rom.mem_r[ROM_DEPTH-1] = addi(2, 1, 12'd100);
    release_reset();
    run(ROM_DEPTH + 16);
    expect_reg("wrap_last", 2, 32'd101);
    expect_reg("wrap_again", 1, 32'd2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
